// File: rtl/sram_like_to_axi.sv
// Bridges an instruction port and a data port (SRAM-like req/addr_ok/data_ok)
// onto a single-beat AXI master, one transaction in flight at a time.
module sram_like_to_axi (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        is_data_q, is_data_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [3:0]  strb_new;
    logic        aw_fire, w_fire;

    always_comb begin
        case (data_size)
            2'd0:    strb_new = 4'b0001 << data_addr[1:0];
            2'd1:    strb_new = 4'b0011 << data_addr[1:0];
            default: strb_new = 4'b1111;
        endcase
    end

    // The two write-channel handshakes are tracked separately so they may land in any order.
    assign aw_fire = (state_q == S_WR) && !aw_done_q && awready;
    assign w_fire  = (state_q == S_WR) && !w_done_q && wready;

    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign arsize = {1'b0, size_q};
    assign awsize = {1'b0, size_q};
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        wstrb_d      = wstrb_q;
        is_data_d    = is_data_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        if (rst) begin
            case (state_q)
                S_IDLE: begin
                    if (data_req) begin
                        data_addr_ok = 1'b1;
                        addr_d       = data_addr;
                        size_d       = data_size;
                        wdata_d      = data_wdata;
                        wstrb_d      = strb_new;
                        is_data_d    = 1'b1;
                        aw_done_d    = 1'b0;
                        w_done_d     = 1'b0;
                        state_d      = data_wr ? S_WR : S_AR;
                    end else if (inst_req) begin
                        inst_addr_ok = 1'b1;
                        addr_d       = inst_addr;
                        size_d       = inst_size;
                        wdata_d      = 32'h0;
                        wstrb_d      = 4'h0;
                        is_data_d    = 1'b0;
                        state_d      = S_AR;
                    end
                end
                S_AR: begin
                    arvalid = 1'b1;
                    if (arready) state_d = S_R;
                end
                S_R: begin
                    rready = 1'b1;
                    if (rvalid) begin
                        if (is_data_q) begin
                            data_data_ok = 1'b1;
                            data_rdata   = rdata;
                        end else begin
                            inst_data_ok = 1'b1;
                            inst_rdata   = rdata;
                        end
                        state_d = S_IDLE;
                    end
                end
                S_WR: begin
                    awvalid = !aw_done_q;
                    wvalid  = !w_done_q;
                    if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = S_B;
                    end else begin
                        aw_done_d = aw_done_q || aw_fire;
                        w_done_d  = w_done_q || w_fire;
                    end
                end
                S_B: begin
                    bready = 1'b1;
                    if (bvalid) begin
                        data_data_ok = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            size_q    <= 2'd0;
            wstrb_q   <= 4'h0;
            is_data_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            wstrb_q   <= wstrb_d;
            is_data_q <= is_data_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_sram_like_to_axi.sv
// Bench for sram_like_to_axi: table vectors, reset corner cases and random
// transactions checked against a cycle-count model of the bridge.
module tb_sram_like_to_axi;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_like_to_axi dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ar_d, r_d, aw_d, w_d, b_d;
        logic        hold;
        int          exp_lat;
        logic [3:0]  exp_strb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_strb(input logic [1:0] size, input logic [1:0] off);
        int m;
        if (size == 2'd0)      m = 1 << off;
        else if (size == 2'd1) m = 3 << off;
        else                   m = 15;
        return 4'(m & 15);
    endfunction

    // One transaction from request to data_ok; the AXI slave side applies the
    // per-channel delays, and each cycle is compared with the expected timeline.
    task automatic run_txn(input vec_t v);
        bit ar_done = 0, r_done = 0, aw_done = 0, w_done = 0, b_done = 0;
        int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
        int wmax = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
        bit rd = !v.wr;
        bit e_ar, e_aw, e_w;
        for (int c = 0; c <= v.exp_lat; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                inst_req   = v.is_data ? v.hold : 1'b1;
                data_req   = v.is_data;
                inst_addr  = v.addr;
                inst_size  = v.size;
                data_addr  = v.addr;
                data_size  = v.size;
                data_wr    = v.wr;
                data_wdata = v.wdata;
            end else begin
                inst_req = v.hold;
                data_req = v.hold;
            end
            arready = !ar_done && ar_cnt >= v.ar_d;
            rvalid  = ar_done && !r_done && r_cnt >= v.r_d;
            rdata   = rvalid ? v.rdata : $urandom;
            awready = !aw_done && aw_cnt >= v.aw_d;
            wready  = !w_done && w_cnt >= v.w_d;
            bvalid  = aw_done && w_done && !b_done && b_cnt >= v.b_d;
            #3;
            e_ar = rd && c >= 1 && c <= 1 + v.ar_d;
            e_aw = v.wr && c >= 1 && c <= 1 + v.aw_d;
            e_w  = v.wr && c >= 1 && c <= 1 + v.w_d;
            chk("inst_addr_ok", 32'(inst_addr_ok), 32'(c == 0 && !v.is_data));
            chk("data_addr_ok", 32'(data_addr_ok), 32'(c == 0 && v.is_data));
            chk("inst_data_ok", 32'(inst_data_ok), 32'(c == v.exp_lat && !v.is_data));
            chk("data_data_ok", 32'(data_data_ok), 32'(c == v.exp_lat && v.is_data));
            chk("arvalid", 32'(arvalid), 32'(e_ar));
            chk("rready", 32'(rready), 32'(rd && c >= 2 + v.ar_d));
            chk("awvalid", 32'(awvalid), 32'(e_aw));
            chk("wvalid", 32'(wvalid), 32'(e_w));
            chk("bready", 32'(bready), 32'(v.wr && c >= 2 + wmax));
            if (e_ar) begin
                chk("araddr", araddr, v.addr);
                chk("arsize", 32'(arsize), 32'(v.size));
            end
            if (e_aw) begin
                chk("awaddr", awaddr, v.addr);
                chk("awsize", 32'(awsize), 32'(v.size));
            end
            if (e_w) begin
                chk("wdata", wdata, v.wdata);
                chk("wstrb", 32'(wstrb), 32'(v.exp_strb));
            end
            if (c == v.exp_lat && rd)
                chk(v.is_data ? "data_rdata" : "inst_rdata",
                    v.is_data ? data_rdata : inst_rdata, v.rdata);
            if (ar_done && !r_done) begin
                if (rvalid && rready) r_done = 1; else r_cnt++;
            end
            if (!ar_done && arvalid) begin
                if (arready) ar_done = 1; else ar_cnt++;
            end
            if (aw_done && w_done && !b_done) begin
                if (bvalid && bready) b_done = 1; else b_cnt++;
            end
            if (!aw_done && awvalid) begin
                if (awready) aw_done = 1; else aw_cnt++;
            end
            if (!w_done && wvalid) begin
                if (wready) w_done = 1; else w_cnt++;
            end
        end
    endtask

    vec_t tbl[9];
    vec_t rv;
    int   wm;

    initial begin
        //          dat wr  sz    addr           wdata          rdata          ar r aw w b hold lat strb
        tbl[0] = '{1'b0, 1'b0, 2'd2, 32'hBFC00000, 32'h0,        32'h3C08BFC0, 0, 0, 0, 0, 0, 1'b0, 2, 4'h0};
        tbl[1] = '{1'b1, 1'b0, 2'd2, 32'h80000010, 32'h0,        32'h12345678, 0, 1, 0, 0, 0, 1'b1, 3, 4'h0};
        tbl[2] = '{1'b0, 1'b0, 2'd2, 32'hBFC00004, 32'h0,        32'h24020001, 1, 0, 0, 0, 0, 1'b0, 3, 4'h0};
        tbl[3] = '{1'b1, 1'b1, 2'd0, 32'h80000003, 32'hAB000000, 32'h0,        0, 0, 2, 0, 1, 1'b0, 5, 4'b1000};
        tbl[4] = '{1'b1, 1'b1, 2'd1, 32'h80000022, 32'h55660000, 32'h0,        0, 0, 0, 1, 0, 1'b0, 3, 4'b1100};
        tbl[5] = '{1'b1, 1'b1, 2'd2, 32'h80000040, 32'hDEADBEEF, 32'h0,        0, 0, 0, 0, 0, 1'b0, 2, 4'b1111};
        tbl[6] = '{1'b0, 1'b0, 2'd2, 32'hBFC00100, 32'h0,        32'hCAFEF00D, 5, 0, 0, 0, 0, 1'b1, 7, 4'h0};
        tbl[7] = '{1'b1, 1'b1, 2'd0, 32'h80000101, 32'h0000CD00, 32'h0,        0, 0, 1, 1, 0, 1'b0, 3, 4'b0010};
        tbl[8] = '{1'b1, 1'b0, 2'd0, 32'h80000007, 32'h0,        32'h99000000, 0, 2, 0, 0, 0, 1'b0, 4, 4'h0};

        rst = 1'b1;
        inst_req = 0; inst_size = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        arready = 0; rdata = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        #2 rst = 1'b0;
        inst_req = 1; data_req = 1;
        #1;
        chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'h0);
        chk("rst_data_addr_ok", 32'(data_addr_ok), 32'h0);
        chk("rst_valids", {28'h0, arvalid, awvalid, wvalid, 1'b0}, 32'h0);
        chk("rst_readies", {30'h0, rready, bready}, 32'h0);
        chk("rst_data_oks", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_awaddr", awaddr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_wstrb", 32'(wstrb), 32'h0);
        @(posedge clk); @(posedge clk); #2;
        inst_req = 0; data_req = 0; rst = 1'b1;

        for (int i = 0; i < 9; i++) run_txn(tbl[i]);

        // Reset while waiting for read data: the transaction must vanish.
        @(posedge clk); #1;
        inst_req = 1; inst_addr = 32'hBFC00200; inst_size = 2'd2; data_req = 0;
        arready = 1; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        #3 chk("v6_addr_ok", 32'(inst_addr_ok), 32'h1);
        @(posedge clk); #1 inst_req = 0;
        #3 chk("v6_arvalid", 32'(arvalid), 32'h1);
        @(posedge clk); #1 arready = 0;
        #3 chk("v6_in_r", 32'(rready), 32'h1);
        #1 rst = 1'b0; inst_req = 1; data_req = 1;
        #1;
        chk("v6_rready", 32'(rready), 32'h0);
        chk("v6_arvalid_rst", 32'(arvalid), 32'h0);
        chk("v6_araddr_rst", araddr, 32'h0);
        chk("v6_addr_ok_rst", {30'h0, inst_addr_ok, data_addr_ok}, 32'h0);
        @(posedge clk); #2;
        inst_req = 0; data_req = 0; rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 rvalid = 1; rdata = 32'hFFFF0000;
            #3;
            chk("v6_no_data_ok", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
            chk("v6_idle_rready", 32'(rready), 32'h0);
        end
        @(posedge clk); #1 rvalid = 0;

        for (int i = 0; i < 200; i++) begin
            rv.is_data = 1'($urandom_range(0, 1));
            rv.wr      = rv.is_data ? 1'($urandom_range(0, 1)) : 1'b0;
            rv.size    = 2'($urandom_range(0, 2));
            rv.addr    = $urandom;
            rv.wdata   = $urandom;
            rv.rdata   = $urandom;
            rv.ar_d    = $urandom_range(0, 3);
            rv.r_d     = $urandom_range(0, 3);
            rv.aw_d    = $urandom_range(0, 3);
            rv.w_d     = $urandom_range(0, 3);
            rv.b_d     = $urandom_range(0, 3);
            rv.hold    = ($urandom_range(0, 3) == 0);
            wm         = (rv.aw_d > rv.w_d) ? rv.aw_d : rv.w_d;
            rv.exp_lat = rv.wr ? 2 + wm + rv.b_d : 2 + rv.ar_d + rv.r_d;
            rv.exp_strb = ref_strb(rv.size, rv.addr[1:0]);
            run_txn(rv);
        end

        @(posedge clk); #1 inst_req = 0; data_req = 0;
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
